// File: rtl/ay_bus_regs.sv
// AY-3-8910 bus interface and register file.
// Decodes BDIR/BC1 bus cycles, holds the sixteen PSG registers R0-R15,
// exposes their fields to the tone/noise/envelope generators and produces
// the shared ay_clk enable pulse.
module ay_bus_regs #(
    parameter int         CLK_DIV   = 16,
    parameter logic [3:0] CHIP_ADDR = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bdir,
    input  logic        bc1,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_oe,
    output logic        ay_clk,
    output logic [11:0] tone_a_period,
    output logic [11:0] tone_b_period,
    output logic [11:0] tone_c_period,
    output logic [4:0]  noise_period,
    output logic [7:0]  mixer,
    output logic [4:0]  amp_a,
    output logic [4:0]  amp_b,
    output logic [4:0]  amp_c,
    output logic [15:0] env_period,
    output logic [3:0]  env_shape,
    output logic        env_restart,
    output logic [7:0]  port_a_out,
    output logic [7:0]  port_b_out,
    input  logic [7:0]  port_a_in,
    input  logic [7:0]  port_b_in
);

    // Bus modes use the {bdir,bc1} encoding so a sampled pair casts directly.
    typedef enum logic [1:0] {
        ST_INACTIVE = 2'b00,
        ST_READ     = 2'b01,
        ST_WRITE    = 2'b10,
        ST_LATCH    = 2'b11
    } busState_t;

    localparam logic [15:0] LP_LAST_COUNT = 16'(CLK_DIV - 1);

    busState_t   r_busState;
    logic        r_selected;
    logic [3:0]  r_addr;
    logic [7:0]  r_regs [16];
    logic [7:0]  r_dout;
    logic        r_doutOe;
    logic        r_envRestart;
    logic [15:0] r_count;

    busState_t   w_mode;
    logic        w_newMode;
    logic [7:0]  w_wrData;
    logic [7:0]  w_readData;

    assign w_mode    = busState_t'({bdir, bc1});
    assign w_newMode = (w_mode != r_busState);

    // Clear the bits a register does not implement so they always read back as 0.
    always_comb begin
        w_wrData = din;
        case (r_addr)
            4'd1, 4'd3, 4'd5, 4'd13:  w_wrData = {4'h0, din[3:0]};
            4'd6, 4'd8, 4'd9, 4'd10:  w_wrData = {3'b000, din[4:0]};
            default:                  w_wrData = din;
        endcase
    end

    // I/O port registers return the pin values when the mixer marks the port as input.
    always_comb begin
        w_readData = r_regs[r_addr];
        if (r_addr == 4'd14 && !r_regs[7][6]) begin
            w_readData = port_a_in;
        end else if (r_addr == 4'd15 && !r_regs[7][7]) begin
            w_readData = port_b_in;
        end
    end

    // Bus FSM: each mode acts once on entry; reads are re-registered every held cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busState   <= ST_INACTIVE;
            r_selected   <= 1'b0;
            r_addr       <= 4'h0;
            r_dout       <= 8'h00;
            r_doutOe     <= 1'b0;
            r_envRestart <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_busState   <= w_mode;
            r_envRestart <= 1'b0;
            r_dout       <= 8'h00;
            r_doutOe     <= 1'b0;
            if (w_newMode) begin
                case (w_mode)
                    ST_LATCH: begin
                        if (din[7:4] == CHIP_ADDR) begin
                            r_selected <= 1'b1;
                            r_addr     <= din[3:0];
                        end else begin
                            r_selected <= 1'b0;
                        end
                    end
                    ST_WRITE: begin
                        if (r_selected) begin
                            r_regs[r_addr] <= w_wrData;
                            if (r_addr == 4'd13) begin
                                r_envRestart <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (w_mode == ST_READ && r_selected) begin
                r_doutOe <= 1'b1;
                r_dout   <= w_readData;
            end
        end
    end

    // Free-running prescaler; the pulse marks the last count of each period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 16'h0000;
        end else if (r_count == LP_LAST_COUNT) begin
            r_count <= 16'h0000;
        end else begin
            r_count <= r_count + 16'h0001;
        end
    end

    assign ay_clk        = (r_count == LP_LAST_COUNT);
    assign dout          = r_dout;
    assign dout_oe       = r_doutOe;
    assign env_restart   = r_envRestart;
    assign tone_a_period = {r_regs[1][3:0], r_regs[0]};
    assign tone_b_period = {r_regs[3][3:0], r_regs[2]};
    assign tone_c_period = {r_regs[5][3:0], r_regs[4]};
    assign noise_period  = r_regs[6][4:0];
    assign mixer         = r_regs[7];
    assign amp_a         = r_regs[8][4:0];
    assign amp_b         = r_regs[9][4:0];
    assign amp_c         = r_regs[10][4:0];
    assign env_period    = {r_regs[12], r_regs[11]};
    assign env_shape     = r_regs[13][3:0];
    assign port_a_out    = r_regs[14];
    assign port_b_out    = r_regs[15];

endmodule

// File: tb/tb_ay_bus_regs.sv
// Directed testbench for ay_bus_regs: reset state, prescaler pulses, latched
// writes with masking, env_restart pulses, chip select, port reads and
// reset asserted during a write.
module tb_ay_bus_regs;

    logic        clk;
    logic        reset;
    logic        bdir;
    logic        bc1;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_oe;
    logic        ay_clk;
    logic [11:0] tone_a_period;
    logic [11:0] tone_b_period;
    logic [11:0] tone_c_period;
    logic [4:0]  noise_period;
    logic [7:0]  mixer;
    logic [4:0]  amp_a;
    logic [4:0]  amp_b;
    logic [4:0]  amp_c;
    logic [15:0] env_period;
    logic [3:0]  env_shape;
    logic        env_restart;
    logic [7:0]  port_a_out;
    logic [7:0]  port_b_out;
    logic [7:0]  port_a_in;
    logic [7:0]  port_b_in;

    int total = 0;
    int bad   = 0;

    ay_bus_regs #(.CLK_DIV(16), .CHIP_ADDR(4'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .bdir          (bdir),
        .bc1           (bc1),
        .din           (din),
        .dout          (dout),
        .dout_oe       (dout_oe),
        .ay_clk        (ay_clk),
        .tone_a_period (tone_a_period),
        .tone_b_period (tone_b_period),
        .tone_c_period (tone_c_period),
        .noise_period  (noise_period),
        .mixer         (mixer),
        .amp_a         (amp_a),
        .amp_b         (amp_b),
        .amp_c         (amp_c),
        .env_period    (env_period),
        .env_shape     (env_shape),
        .env_restart   (env_restart),
        .port_a_out    (port_a_out),
        .port_b_out    (port_b_out),
        .port_a_in     (port_a_in),
        .port_b_in     (port_b_in)
    );

    // 10-unit system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one bus cycle at a negedge and wait until the following negedge.
    task automatic applyStimulus(input logic b, input logic c, input logic [7:0] d);
        bdir = b;
        bc1  = c;
        din  = d;
        @(negedge clk);
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Linear directed sequence.
    initial begin
        reset     = 1'b0;
        bdir      = 1'b0;
        bc1       = 1'b0;
        din       = 8'h00;
        port_a_in = 8'h00;
        port_b_in = 8'h00;
        repeat (3) @(negedge clk);

        checkOutput("rst_dout",      16'(dout), 16'h0);
        checkOutput("rst_dout_oe",   16'(dout_oe), 16'h0);
        checkOutput("rst_ay_clk",    16'(ay_clk), 16'h0);
        checkOutput("rst_env_rst",   16'(env_restart), 16'h0);
        checkOutput("rst_tone_a",    16'(tone_a_period), 16'h0);
        checkOutput("rst_mixer",     16'(mixer), 16'h0);
        checkOutput("rst_env_per",   env_period, 16'h0);

        // Prescaler: pulses on cycles 16, 32, 48 after release, one cycle wide.
        reset = 1'b1;
        for (int n = 1; n <= 48; n++) begin
            checkOutput($sformatf("ay_clk_c%0d", n), 16'(ay_clk), (n % 16 == 0) ? 16'h1 : 16'h0);
            @(negedge clk);
        end
        checkOutput("idle_noise", 16'(noise_period), 16'h0);
        checkOutput("idle_port_a", 16'(port_a_out), 16'h0);

        // R6 write, masked to 5 bits, single write per held WRITE.
        applyStimulus(1'b1, 1'b1, 8'h06);
        applyStimulus(1'b1, 1'b0, 8'hFF);
        checkOutput("noise_write", 16'(noise_period), 16'h1F);
        applyStimulus(1'b1, 1'b0, 8'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("noise_held", 16'(noise_period), 16'h1F);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("r6_read_oe", 16'(dout_oe), 16'h1);
        checkOutput("r6_read", 16'(dout), 16'h1F);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("r6_read_hold", 16'(dout), 16'h1F);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("r6_after_oe", 16'(dout_oe), 16'h0);
        checkOutput("r6_after_dout", 16'(dout), 16'h0);

        // R13 writes: each fires one env_restart pulse.
        applyStimulus(1'b1, 1'b1, 8'h0D);
        applyStimulus(1'b1, 1'b0, 8'h0A);
        checkOutput("env_shape", 16'(env_shape), 16'hA);
        checkOutput("env_rst1_hi", 16'(env_restart), 16'h1);
        applyStimulus(1'b1, 1'b0, 8'h0A);
        checkOutput("env_rst1_lo", 16'(env_restart), 16'h0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h0D);
        checkOutput("env_rst_latch", 16'(env_restart), 16'h0);
        applyStimulus(1'b1, 1'b0, 8'h0A);
        checkOutput("env_rst2_hi", 16'(env_restart), 16'h1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("env_rst2_lo", 16'(env_restart), 16'h0);
        checkOutput("env_shape2", 16'(env_shape), 16'hA);

        // Latch of another chip address deselects; write and read are ignored.
        applyStimulus(1'b1, 1'b1, 8'h57);
        applyStimulus(1'b1, 1'b0, 8'h33);
        checkOutput("desel_env_rst", 16'(env_restart), 16'h0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("desel_shape", 16'(env_shape), 16'hA);
        checkOutput("desel_noise", 16'(noise_period), 16'h1F);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("desel_read_oe", 16'(dout_oe), 16'h0);
        checkOutput("desel_read_dout", 16'(dout), 16'h0);

        // Port A read: output latch when mixer[6]=1, pins when mixer[6]=0.
        port_a_in = 8'hC3;
        applyStimulus(1'b1, 1'b1, 8'h07);
        applyStimulus(1'b1, 1'b0, 8'h40);
        applyStimulus(1'b1, 1'b1, 8'h0E);
        applyStimulus(1'b1, 1'b0, 8'h5A);
        checkOutput("mixer_40", 16'(mixer), 16'h40);
        checkOutput("port_a_out", 16'(port_a_out), 16'h5A);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("r14_out_read", 16'(dout), 16'h5A);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h07);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h0E);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("r14_in_read", 16'(dout), 16'hC3);
        checkOutput("r14_in_oe", 16'(dout_oe), 16'h1);
        port_a_in = 8'h11;
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("r14_in_track", 16'(dout), 16'h11);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("r14_leave_oe", 16'(dout_oe), 16'h0);

        // Tone A from R0/R1 with R1 masked to 4 bits.
        applyStimulus(1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h34);
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b0, 8'hF2);
        checkOutput("tone_a", 16'(tone_a_period), 16'h234);

        // Reset asserted in the middle of a WRITE to R2.
        applyStimulus(1'b1, 1'b1, 8'h02);
        bdir = 1'b1;
        bc1  = 1'b0;
        din  = 8'h56;
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_tone_a", 16'(tone_a_period), 16'h0);
        checkOutput("midrst_tone_b", 16'(tone_b_period), 16'h0);
        checkOutput("midrst_shape", 16'(env_shape), 16'h0);
        checkOutput("midrst_port_a", 16'(port_a_out), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h56);
        applyStimulus(1'b1, 1'b0, 8'h56);
        checkOutput("post_rst_tone_b", 16'(tone_b_period), 16'h0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("post_rst_tone_a", 16'(tone_a_period), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
